// File: rtl/memctl.sv
// Data-memory access controller: sequences loads, word stores and read-modify-write stores over a req/ack bus.
// Optional `MEMCTL_TIMEOUT_EN adds a per-phase wait counter that aborts with err after TIMEOUT unacked cycles.
module memctl #(
   parameter int ADDR_W  = 30,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rw,
   input  logic [2:0]        func,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FIN} state_t;

   state_t            r_state;
   logic              r_rmw;
   logic [31:0]       r_rdata;
   logic [ADDR_W-1:0] r_addr;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_mem_rd;
   logic              r_mem_wr;

`ifdef MEMCTL_TIMEOUT_EN
   localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [WAIT_W-1:0] r_wait;
   logic              w_expire;
   assign w_expire = (r_wait == WAIT_W'(TIMEOUT - 1));
`endif

   // Request levels and done/err are registered alongside the state so they track it exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rmw    <= 1'b0;
         r_rdata  <= '0;
         r_addr   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_mem_rd <= 1'b0;
         r_mem_wr <= 1'b0;
`ifdef MEMCTL_TIMEOUT_EN
         r_wait   <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr <= addr;
                  r_rmw  <= rw && (func != 3'b011);
                  r_busy <= 1'b1;
`ifdef MEMCTL_TIMEOUT_EN
                  r_wait <= '0;
`endif
                  if (func == 3'b111) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end else if (rw && func == 3'b011) begin
                     r_state  <= S_WRITE;
                     r_mem_wr <= 1'b1;
                  end else begin
                     r_state  <= S_READ;
                     r_mem_rd <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (mem_ack) begin
                  r_rdata  <= mem_rdata;
                  r_mem_rd <= 1'b0;
                  if (r_rmw) begin
                     r_state  <= S_WRITE;
                     r_mem_wr <= 1'b1;
`ifdef MEMCTL_TIMEOUT_EN
                     r_wait   <= '0;
`endif
                  end else begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end
               end
`ifdef MEMCTL_TIMEOUT_EN
               else if (w_expire) begin
                  r_mem_rd <= 1'b0;
                  r_state  <= S_FIN;
                  r_done   <= 1'b1;
                  r_err    <= 1'b1;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
`endif
            end
            S_WRITE: begin
               if (mem_ack) begin
                  r_mem_wr <= 1'b0;
                  r_state  <= S_FIN;
                  r_done   <= 1'b1;
               end
`ifdef MEMCTL_TIMEOUT_EN
               else if (w_expire) begin
                  r_mem_wr <= 1'b0;
                  r_state  <= S_FIN;
                  r_done   <= 1'b1;
                  r_err    <= 1'b1;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
`endif
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rdata     = r_rdata;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign mem_addr  = r_addr;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   // The converter rebuilds wdata from the held rdata during WRITE, so pass it through unregistered.
   assign mem_wdata = r_mem_wr ? wdata : 32'h0;

endmodule

// File: tb/tb_memctl.sv
// Directed bench for memctl: load, RMW store, waited word store, upper-immediate, async reset mid-write.
// With MEMCTL_TIMEOUT_EN defined it also runs the load-timeout abort case (TIMEOUT = 4).
module tb_memctl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        rw;
   logic [2:0]  func;
   logic [29:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks   = 0;
   int failures = 0;

   memctl #(.ADDR_W(30), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .func(func), .addr(addr),
      .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic request(input logic r, input logic [2:0] f, input logic [29:0] a);
      start = 1'b1;
      rw    = r;
      func  = f;
      addr  = a;
      step();
      start = 1'b0;
   endtask

   initial begin
      int wr_cycles;
      int rd_seen;
      rst = 1'b1; start = 1'b0; rw = 1'b0; func = 3'b000; addr = '0;
      wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
      step();
      step();
      check("rst_rdata", rdata, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_req", {30'h0, mem_rd, mem_wr}, 32'h0);
      check("rst_addr", {2'b0, mem_addr}, 32'h0);
      rst = 1'b0;
      step();

      // Load, zero wait states.
      request(1'b0, 3'b010, 30'h40);
      check("ld_c1_rd", {31'h0, mem_rd}, 32'h1);
      check("ld_c1_busy", {31'h0, busy}, 32'h1);
      check("ld_c1_done", {31'h0, done}, 32'h0);
      check("ld_addr", {2'b0, mem_addr}, 32'h40);
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      check("ld_c2_done", {31'h0, done}, 32'h1);
      check("ld_c2_rd", {31'h0, mem_rd}, 32'h0);
      check("ld_rdata", rdata, 32'hDEADBEEF);
      check("ld_c2_busy", {31'h0, busy}, 32'h1);

      // Back-to-back: RMW store accepted in the first idle cycle after FIN.
      step();
      check("ld_idle_busy", {31'h0, busy}, 32'h0);
      check("ld_hold_rdata", rdata, 32'hDEADBEEF);
      request(1'b1, 3'b000, 30'h41);
      check("rmw_c1_rd", {31'h0, mem_rd}, 32'h1);
      check("rmw_c1_wr", {31'h0, mem_wr}, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h11223344;
      step();
      mem_rdata = 32'h0;
      check("rmw_c2_wr", {31'h0, mem_wr}, 32'h1);
      check("rmw_c2_rd", {31'h0, mem_rd}, 32'h0);
      check("rmw_rdata", rdata, 32'h11223344);
      wdata = 32'h1122AA44;
      #1;
      check("rmw_wdata", mem_wdata, 32'h1122AA44);
      step();
      mem_ack = 1'b0;
      check("rmw_c3_done", {31'h0, done}, 32'h1);
      check("rmw_c3_wr", {31'h0, mem_wr}, 32'h0);
      check("rmw_c3_wdata", mem_wdata, 32'h0);
      check("rmw_hold_rdata", rdata, 32'h11223344);
      step();

      // Word store, three wait states.
      wdata = 32'hCAFEF00D;
      request(1'b1, 3'b011, 30'h3FF_FFFF);
      wr_cycles = 0;
      rd_seen = 0;
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) mem_ack = 1'b1;
         #1;
         wr_cycles += int'(mem_wr);
         rd_seen += int'(mem_rd);
         if (i == 1) check("ws_wdata", mem_wdata, 32'hCAFEF00D);
         check("ws_nodone", {31'h0, done}, 32'h0);
         step();
      end
      mem_ack = 1'b0;
      check("ws_wr_cycles", wr_cycles, 32'd4);
      check("ws_no_read", rd_seen, 32'd0);
      check("ws_c5_done", {31'h0, done}, 32'h1);
      check("ws_addr", {2'b0, mem_addr}, 32'h3FF_FFFF);
      check("ws_rdata_kept", rdata, 32'h11223344);
      step();

      // Upper-immediate; start re-asserted during FIN must be ignored.
      request(1'b0, 3'b111, 30'h7);
      check("ui_c1_done", {31'h0, done}, 32'h1);
      check("ui_c1_busy", {31'h0, busy}, 32'h1);
      check("ui_c1_req", {30'h0, mem_rd, mem_wr}, 32'h0);
      request(1'b0, 3'b010, 30'h99);
      check("ui_c2_busy", {31'h0, busy}, 32'h0);
      check("ui_c2_req", {30'h0, mem_rd, mem_wr}, 32'h0);
      check("ui_c2_addr", {2'b0, mem_addr}, 32'h7);
      step();

      // Asynchronous reset during WRITE with ack withheld.
      wdata = 32'h55AA55AA;
      request(1'b1, 3'b011, 30'h123);
      check("rw_c1_wr", {31'h0, mem_wr}, 32'h1);
      rst = 1'b1;
      #1;
      check("rw_async_wr", {31'h0, mem_wr}, 32'h0);
      check("rw_async_wdata", mem_wdata, 32'h0);
      check("rw_async_busy", {31'h0, busy}, 32'h0);
      check("rw_async_rdata", rdata, 32'h0);
      check("rw_async_addr", {2'b0, mem_addr}, 32'h0);
      #1;
      rst = 1'b0;
      step();
      request(1'b0, 3'b100, 30'h2A);
      check("rw_next_rd", {31'h0, mem_rd}, 32'h1);
      mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
      step();
      mem_ack = 1'b0;
      check("rw_next_done", {31'h0, done}, 32'h1);
      check("rw_next_rdata", rdata, 32'h0BADF00D);
      check("rw_next_err", {31'h0, err}, 32'h0);
      step();

`ifdef MEMCTL_TIMEOUT_EN
      // Load with ack never asserted: abort after four wait cycles.
      request(1'b0, 3'b010, 30'h50);
      for (int i = 1; i <= 4; i++) begin
         check("to_rd", {31'h0, mem_rd}, 32'h1);
         check("to_noerr", {31'h0, err}, 32'h0);
         step();
      end
      check("to_done", {31'h0, done}, 32'h1);
      check("to_err", {31'h0, err}, 32'h1);
      check("to_rd_drop", {31'h0, mem_rd}, 32'h0);
      check("to_rdata", rdata, 32'h0BADF00D);
      step();
      check("to_err_pulse", {31'h0, err}, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memctl.md
# memctl

Sequential data-memory access controller that sits directly between the load/store data converter and the data-memory bus. It sequences each load, full-word store and sub-word/unaligned store (read-modify-write) as a bus handshake. It holds the fetched memory word stable as the converter's memory-data input and stalls the pipeline until the access completes.

## Interface

Parameters:
- `ADDR_W`, 30, word-address width; byte address bits [31:2].
- `TIMEOUT`, 255, maximum wait cycles per bus phase before abort; used only with `MEMCTL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  access request; sampled only in IDLE.
- `rw`  in  1  1 = store, 0 = load.
- `func`  in  3  converter function code; 3'b011 = full word, 3'b111 = upper-immediate (no memory access), others = sub-word/partial.
- `addr`  in  ADDR_W  word address from the converter; captured at accept.
- `wdata`  in  32  merged store word from the converter; consumed during WRITE.
- `rdata`  out  32  registered memory word; drives the converter's memory-data input.
- `busy`  out  1  high from the cycle after accept until FIN, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle abort pulse, coincident with `done`.
- `mem_addr`  out  ADDR_W  registered captured address.
- `mem_wdata`  out  32  equals `wdata` while `mem_wr` = 1, otherwise 0.
- `mem_rd`  out  1  read request level.
- `mem_wr`  out  1  write request level.
- `mem_rdata`  in  32  memory read data; valid with `mem_ack`.
- `mem_ack`  in  1  memory completes the current phase.

## Operation

- States: IDLE, READ, WRITE, FIN.
- IDLE with `start` = 1 captures `addr`, `rw` and `func`, then transitions:
  - `func` = 111 → FIN.
  - Load → READ.
  - Store with `func` = 011 → WRITE.
  - Any other store → READ, then WRITE (read-modify-write).
- READ: `mem_rd` = 1. On `mem_ack`, `rdata` ← `mem_rdata`. Next state is WRITE for an RMW store, otherwise FIN.
- WRITE: `mem_wr` = 1, `mem_wdata` = `wdata`. The converter recomputes `wdata` combinationally from the held `rdata`. On `mem_ack` → FIN.
- FIN: `done` = 1 for one cycle, then IDLE.
- `mem_rd` and `mem_wr` are never high together. Both are decoded from state, so they drop in the same cycle the state leaves.
- `rdata` changes only on an acked READ. It holds its value across WRITE, FIN and subsequent idle cycles.
- `mem_ack` outside READ/WRITE is ignored. `start` while not IDLE is ignored.
- The pipeline holds `rin`/`func` stable while `busy` = 1.

## Timing

- Reset values: state IDLE; `rdata`, `mem_addr` = 0; `busy`, `done`, `err`, `mem_rd`, `mem_wr` = 0; `mem_wdata` = 0. Reset takes effect immediately at any point, mid-access included. Request lines drop without waiting for ack.
- Latency from the accept edge to `done`, with zero wait states (ack in the first request cycle):
  - Upper-immediate: 1 cycle.
  - Word store: 2 cycles.
  - Load: 2 cycles.
  - RMW store: 3 cycles.
- Each wait cycle (request high, ack low) adds 1 cycle.
- `busy` is low in the cycle `start` is sampled and high from the next cycle through FIN. A new `start` is accepted in the first IDLE cycle after FIN, so back-to-back accesses are possible.

## Configuration

- `MEMCTL_TIMEOUT_EN` defined:
  - An 8-bit-or-wider wait counter clears on entry to READ/WRITE and increments each unacked cycle.
  - When the count reaches `TIMEOUT`, the access aborts to FIN with `err` = 1. The write is not issued and `rdata` is not updated.
- `MEMCTL_TIMEOUT_EN` undefined: waits indefinitely; `err` is constant 0 and no counter exists.

## Test plan

- Load, addr 0x0000_0040, `mem_rdata` = 0xDEADBEEF, ack immediate → `mem_rd` high 1 cycle, `done` 2 cycles after accept, `rdata` = 0xDEADBEEF.
- Sub-word store (`func` 000), memory word 0x11223344, converter merges byte 0xAA at offset 1 → READ then WRITE, `mem_wdata` = 0x1122AA44, `done` 3 cycles after accept.
- Word store (`func` 011), `wdata` 0xCAFEF00D, ack after 3 wait cycles → no READ, `mem_wr` high 4 cycles, `done` 5 cycles after accept.
- Upper-immediate (`func` 111) → no `mem_rd`/`mem_wr`, `done` 1 cycle after accept; `start` re-asserted during `busy` is ignored.
- `rst` pulsed while in WRITE with ack withheld → `mem_wr` drops asynchronously, all outputs 0, next `start` accepted normally.
- With `MEMCTL_TIMEOUT_EN` and `TIMEOUT` = 4, load with ack never asserted → `err` and `done` pulse together after 4 wait cycles, `rdata` unchanged.
